// File: rtl/keypad_code_lock.sv
// Keypad code lock: debounces the priority-encoder key code, turns each clean
// press into one digit event, collects DIGITS digits and checks them against a secret.
module keypad_code_lock #(
  parameter int DIGITS         = 4,
  parameter int DEBOUNCE       = 4,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            code,
  input  logic [4*DIGITS-1:0]   secret,
  output logic                  digit_valid,
  output logic [3:0]            digit,
  output logic [3:0]            count,
  output logic                  unlocked,
  output logic                  error,
  output logic                  locked_out
);

  localparam int EW = 4 * DIGITS;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam int UW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int TW = (UW > LW) ? UW : LW;
  localparam int FW = $clog2(MAX_TRIES + 1);

  localparam logic [SW-1:0] DB_MAX = SW'(DEBOUNCE);
  localparam logic [TW-1:0] U_LAST = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] L_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_TRIES);
  localparam logic [3:0]    DIG_N  = 4'(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT
  } state_t;

  state_t          state_q;
  logic [3:0]      sample;
  logic [3:0]      prev_q;
  logic [SW-1:0]   stable_q, stable_d;
  logic            armed_q;
  logic            accept;
  logic [EW-1:0]   entry_q;
  logic [TW-1:0]   timer_q;
  logic [FW-1:0]   fail_q, fail_d;
  logic [3:0]      count_d;

  always_comb begin
    sample = (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
    if (sample != prev_q)        stable_d = SW'(1);
    else if (stable_q == DB_MAX) stable_d = stable_q;
    else                         stable_d = stable_q + SW'(1);
    accept  = (stable_d == DB_MAX) && (sample != 4'd0) && armed_q;
    count_d = (state_q == S_IDLE) ? 4'd1 : count + 4'd1;
    fail_d  = (fail_q == F_MAX) ? fail_q : fail_q + FW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prev_q      <= 4'd0;
      stable_q    <= '0;
      armed_q     <= 1'b1;
      entry_q     <= '0;
      timer_q     <= '0;
      fail_q      <= '0;
      digit_valid <= 1'b0;
      digit       <= 4'd0;
      count       <= 4'd0;
      unlocked    <= 1'b0;
      error       <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      prev_q      <= sample;
      stable_q    <= stable_d;
      digit_valid <= 1'b0;
      error       <= 1'b0;
      // Any accepted press disarms, even when the FSM is busy and discards it.
      if (accept)
        armed_q <= 1'b0;
      else if (stable_d == DB_MAX && sample == 4'd0)
        armed_q <= 1'b1;

      case (state_q)
        S_IDLE, S_ENTRY: begin
          if (accept) begin
            digit       <= sample;
            digit_valid <= 1'b1;
            entry_q     <= (entry_q << 4) | EW'(sample);
            count       <= count_d;
            state_q     <= (count_d == DIG_N) ? S_CHECK : S_ENTRY;
          end
        end
        S_CHECK: begin
          if (entry_q == secret) begin
            fail_q   <= '0;
            timer_q  <= '0;
            unlocked <= 1'b1;
            state_q  <= S_OPEN;
          end else begin
            error   <= 1'b1;
            state_q <= S_FAIL;
          end
        end
        S_OPEN: begin
          if (timer_q == U_LAST) begin
            unlocked <= 1'b0;
            count    <= 4'd0;
            state_q  <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_FAIL: begin
          fail_q <= fail_d;
          if (fail_d == F_MAX) begin
            timer_q    <= '0;
            locked_out <= 1'b1;
            state_q    <= S_LOCKOUT;
          end else begin
            count   <= 4'd0;
            state_q <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (timer_q == L_LAST) begin
            locked_out <= 1'b0;
            fail_q     <= '0;
            count      <= 4'd0;
            state_q    <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: directed scenarios with literal expectations plus
// randomized key traffic checked every cycle against a behavioural model.
module tb_keypad_code_lock;
  localparam int DIGITS = 4, DEBOUNCE = 4, UNLOCK_CYCLES = 8;
  localparam int MAX_TRIES = 3, LOCKOUT_CYCLES = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          code = 4'd0;
  logic [4*DIGITS-1:0] secret = 16'h1234;
  logic                digit_valid, unlocked, error, locked_out;
  logic [3:0]          digit, count;

  always #5 clk = ~clk;

  keypad_code_lock #(
    .DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE), .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .secret(secret),
    .digit_valid(digit_valid), .digit(digit), .count(count),
    .unlocked(unlocked), .error(error), .locked_out(locked_out)
  );

  int cmp_n = 0, fail_n = 0;
  int dv_tot = 0, err_tot = 0, unl_tot = 0, lock_tot = 0;

  task automatic chk(input string name, input int act, input int req);
    cmp_n++;
    if (act != req) begin
      fail_n++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: window of recent samples, list of entered digits and
  // a per-cycle schedule of (unlocked, error, locked_out) for a busy lock.
  logic [3:0] win[$];
  logic [3:0] ent[$];
  logic [2:0] pend[$];
  bit         m_armed = 1'b1;
  int         m_fails = 0;
  logic       exp_dv = 1'b0, exp_unl = 1'b0, exp_err = 1'b0, exp_lock = 1'b0;
  logic [3:0] exp_digit = 4'd0, exp_count = 4'd0;

  function automatic logic [3:0] norm(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  task automatic model_reset();
    win.delete(); ent.delete(); pend.delete();
    m_armed = 1'b1; m_fails = 0;
    exp_dv = 0; exp_unl = 0; exp_err = 0; exp_lock = 0;
    exp_digit = 0; exp_count = 0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    bit steady, acc;
    logic [4*DIGITS-1:0] val;
    s = norm(code);
    win.push_back(s);
    if (win.size() > DEBOUNCE) void'(win.pop_front());
    steady = (win.size() == DEBOUNCE);
    foreach (win[i]) if (win[i] != s) steady = 0;
    acc = steady && (s != 0) && m_armed;
    if (steady && s == 0) m_armed = 1;
    if (acc) m_armed = 0;
    exp_dv = 0;
    if (pend.size() > 0) begin
      void'(pend.pop_front());
      if (pend.size() == 0) ent.delete();
    end else if (acc) begin
      ent.push_back(s);
      exp_dv = 1;
      exp_digit = s;
      if (ent.size() == DIGITS) begin
        val = '0;
        foreach (ent[i]) val = (val << 4) | (4*DIGITS)'(ent[i]);
        pend.push_back(3'b000);
        if (val == secret) begin
          m_fails = 0;
          repeat (UNLOCK_CYCLES) pend.push_back(3'b100);
        end else begin
          m_fails++;
          pend.push_back(3'b010);
          if (m_fails == MAX_TRIES) begin
            repeat (LOCKOUT_CYCLES) pend.push_back(3'b001);
            m_fails = 0;
          end
        end
      end
    end
    exp_count = (pend.size() > 0) ? 4'(DIGITS) : 4'(ent.size());
    {exp_unl, exp_err, exp_lock} = (pend.size() > 0) ? pend[0] : 3'b000;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("digit_valid", int'(digit_valid), int'(exp_dv));
      chk("digit",       int'(digit),       int'(exp_digit));
      chk("count",       int'(count),       int'(exp_count));
      chk("unlocked",    int'(unlocked),    int'(exp_unl));
      chk("error",       int'(error),       int'(exp_err));
      chk("locked_out",  int'(locked_out),  int'(exp_lock));
      dv_tot   += int'(digit_valid);
      err_tot  += int'(error);
      unl_tot  += int'(unlocked);
      lock_tot += int'(locked_out);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    code = 4'd0;
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    code = k;
    repeat (hold) tick();
    code = 4'd0;
    repeat (rel) tick();
  endtask

  task automatic enter(input logic [15:0] seq);
    for (int i = DIGITS - 1; i >= 0; i--) press(seq[4*i +: 4], 6, 6);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dv"},    int'(digit_valid), 0);
    chk({tag, "_digit"}, int'(digit),       0);
    chk({tag, "_count"}, int'(count),       0);
    chk({tag, "_unl"},   int'(unlocked),    0);
    chk({tag, "_err"},   int'(error),       0);
    chk({tag, "_lock"},  int'(locked_out),  0);
  endtask

  task automatic async_reset(input string tag);
    code = 4'd0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_zero(tag);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  int s_dv, s_err, s_unl, s_lock, r;

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    #2 rst_n = 1'b1;
    tick();
    idle(5);

    // Clean press: accepted on the 4th sampling edge, once while held.
    s_dv = dv_tot;
    code = 4'd5;
    repeat (3) tick();
    chk("clean_early_dv", int'(digit_valid), 0);
    tick();
    chk("clean_dv", int'(digit_valid), 1);
    chk("clean_digit", int'(digit), 5);
    chk("clean_count", int'(count), 1);
    chk("model_digit", int'(exp_digit), 5);
    repeat (6) tick();
    idle(6);
    chk("clean_pulses", dv_tot - s_dv, 1);

    // Bounce, then a stable 3.
    s_dv = dv_tot;
    for (int i = 0; i < 4; i++) begin code = (i % 2 == 0) ? 4'd3 : 4'd0; tick(); end
    press(4'd3, 6, 6);
    chk("bounce_pulses", dv_tot - s_dv, 1);
    chk("bounce_digit", int'(digit), 3);
    chk("bounce_count", int'(count), 2);

    // Slide from 5 to 7 without release: only 5 counts.
    s_dv = dv_tot;
    code = 4'd5; repeat (6) tick();
    code = 4'd7; repeat (6) tick();
    idle(6);
    chk("slide_pulses", dv_tot - s_dv, 1);
    chk("slide_digit", int'(digit), 5);
    chk("slide_count", int'(count), 3);

    // Fourth digit completes a wrong entry (5,3,5,9).
    s_err = err_tot;
    press(4'd9, 6, 6);
    idle(10);
    chk("wrong_err", err_tot - s_err, 1);
    chk("wrong_count_after", int'(count), 0);

    async_reset("rst_a");
    idle(6);

    // Correct code.
    s_unl = unl_tot; s_err = err_tot;
    enter(16'h1234);
    idle(20);
    chk("open_cycles", unl_tot - s_unl, UNLOCK_CYCLES);
    chk("open_err", err_tot - s_err, 0);
    chk("open_count_after", int'(count), 0);

    // Three wrong attempts trigger lockout; a press during lockout is dropped.
    s_err = err_tot; s_lock = lock_tot;
    enter(16'h1235); idle(10);
    chk("try1_err", err_tot - s_err, 1);
    enter(16'h1235); idle(10);
    chk("try2_err", err_tot - s_err, 2);
    chk("try2_lock", lock_tot - s_lock, 0);
    enter(16'h1235);
    s_dv = dv_tot;
    press(4'd7, 6, 6);
    chk("lockout_press_dv", dv_tot - s_dv, 0);
    idle(12);
    chk("try3_err", err_tot - s_err, 3);
    chk("lockout_cycles", lock_tot - s_lock, LOCKOUT_CYCLES);
    chk("lockout_count_after", int'(count), 0);

    // Fail counter restarted: a single wrong attempt does not lock out.
    s_err = err_tot; s_lock = lock_tot;
    enter(16'h9999); idle(10);
    chk("post_lock_err", err_tot - s_err, 1);
    chk("post_lock_lock", lock_tot - s_lock, 0);
    s_unl = unl_tot;
    enter(16'h1234); idle(20);
    chk("post_lock_open", unl_tot - s_unl, UNLOCK_CYCLES);

    // Reset in the middle of an entry.
    press(4'd1, 6, 6);
    press(4'd2, 6, 6);
    chk("mid_count", int'(count), 2);
    async_reset("rst_mid");
    idle(6);
    s_unl = unl_tot;
    enter(16'h1234); idle(20);
    chk("after_rst_open", unl_tot - s_unl, UNLOCK_CYCLES);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 19);
      if (r < 5) begin
        for (int i = DIGITS - 1; i >= 0; i--)
          press(secret[4*i +: 4], $urandom_range(3, 7), $urandom_range(3, 7));
      end else if (r < 8) begin
        repeat ($urandom_range(2, 6)) begin code = 4'($urandom_range(0, 15)); tick(); end
      end else if (r == 8) begin
        code = 4'($urandom_range(1, 9)); repeat ($urandom_range(4, 7)) tick();
        code = 4'($urandom_range(1, 9)); repeat ($urandom_range(4, 7)) tick();
        idle($urandom_range(1, 6));
      end else if (r == 19) begin
        @(posedge clk); #($urandom_range(2, 8)) rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #($urandom_range(2, 8)) rst_n = 1'b1;
        tick();
      end else begin
        press(4'($urandom_range(1, 15)), $urandom_range(1, 8), $urandom_range(1, 8));
      end
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
